// File: rtl/alu_cond_resolve.sv
// Branch condition resolver: decodes compare flags per transaction, buffers results
// in a 2-entry valid/ready FIFO and keeps saturating taken/total statistics.
module alu_cond_resolve #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cond,
  input  logic [ADDR_W-1:0] in_target,
  input  logic [5:0]        cmp_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [ADDR_W-1:0] out_target,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  total_cnt,
  output logic              flag_err
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e              state_q, state_d;
  logic                head_taken_q, head_taken_d;
  logic [ADDR_W-1:0]   head_target_q, head_target_d;
  logic                tail_taken_q, tail_taken_d;
  logic [ADDR_W-1:0]   tail_target_q, tail_target_d;
  logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]    total_cnt_q, total_cnt_d;
  logic                flag_err_q, flag_err_d;

  logic equ, neq, lth, lte, gth, gte;
  logic push, pop, resolved, flags_bad;

  assign {gte, gth, lte, lth, neq, equ} = cmp_flags;

  assign in_ready   = (state_q != StFull);
  assign out_valid  = (state_q != StEmpty);
  assign out_taken  = head_taken_q;
  assign out_target = head_target_q;
  assign taken_cnt  = taken_cnt_q;
  assign total_cnt  = total_cnt_q;
  assign flag_err   = flag_err_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    resolved = 1'b0;
    case (in_cond)
      3'd0:    resolved = equ;
      3'd1:    resolved = neq;
      3'd2:    resolved = lth;
      3'd3:    resolved = lte;
      3'd4:    resolved = gth;
      3'd5:    resolved = gte;
      3'd6:    resolved = 1'b1;
      default: resolved = 1'b0;
    endcase
  end

  // Mutually exclusive pairs must differ, and lte must be the union of lth and equ.
  assign flags_bad = (equ == neq) | (lth == gte) | (lte == gth) | (lte != (lth | equ));

  always_comb begin
    state_d       = state_q;
    head_taken_d  = head_taken_q;
    head_target_d = head_target_q;
    tail_taken_d  = tail_taken_q;
    tail_target_d = tail_target_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          head_taken_d  = resolved;
          head_target_d = in_target;
          state_d       = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          head_taken_d  = resolved;
          head_target_d = in_target;
        end else if (push) begin
          tail_taken_d  = resolved;
          tail_target_d = in_target;
          state_d       = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          head_taken_d  = tail_taken_q;
          head_target_d = tail_target_q;
          state_d       = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    total_cnt_d = total_cnt_q;
    flag_err_d  = flag_err_q;
    if (cnt_clr) begin
      taken_cnt_d = '0;
      total_cnt_d = '0;
      flag_err_d  = 1'b0;
    end else if (push) begin
      if (total_cnt_q != '1) total_cnt_d = total_cnt_q + 1'b1;
      if (resolved && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + 1'b1;
      if (flags_bad) flag_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StEmpty;
      head_taken_q  <= 1'b0;
      head_target_q <= '0;
      tail_taken_q  <= 1'b0;
      tail_target_q <= '0;
      taken_cnt_q   <= '0;
      total_cnt_q   <= '0;
      flag_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_taken_q  <= head_taken_d;
      head_target_q <= head_target_d;
      tail_taken_q  <= tail_taken_d;
      tail_target_q <= tail_target_d;
      taken_cnt_q   <= taken_cnt_d;
      total_cnt_q   <= total_cnt_d;
      flag_err_q    <= flag_err_d;
    end
  end

endmodule

// File: tb/tb_alu_cond_resolve.sv
// Directed self-checking bench for alu_cond_resolve; a second instance with a 4-bit
// counter width shares the stimulus to exercise saturation.
module tb_alu_cond_resolve;

  localparam int unsigned AddrW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, out_ready, cnt_clr;
  logic [2:0]       in_cond;
  logic [AddrW-1:0] in_target;
  logic [5:0]       cmp_flags;

  logic             in_ready, out_valid, out_taken, flag_err;
  logic [AddrW-1:0] out_target;
  logic [15:0]      taken_cnt, total_cnt;

  logic             in_ready4, out_valid4, out_taken4, flag_err4;
  logic [AddrW-1:0] out_target4;
  logic [3:0]       taken_cnt4, total_cnt4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_cond_resolve #(.ADDR_W(AddrW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond),
    .in_target(in_target), .cmp_flags(cmp_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_taken(out_taken), .out_target(out_target),
    .cnt_clr(cnt_clr), .taken_cnt(taken_cnt), .total_cnt(total_cnt), .flag_err(flag_err)
  );

  alu_cond_resolve #(.ADDR_W(AddrW), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_cond(in_cond),
    .in_target(in_target), .cmp_flags(cmp_flags), .out_valid(out_valid4),
    .out_ready(out_ready), .out_taken(out_taken4), .out_target(out_target4),
    .cnt_clr(cnt_clr), .taken_cnt(taken_cnt4), .total_cnt(total_cnt4), .flag_err(flag_err4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [5:0] f,
                       input logic [AddrW-1:0] t);
    in_valid  = v;
    in_cond   = c;
    cmp_flags = f;
    in_target = t;
  endtask

  logic [7:0] gt_expect;

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 6'b0, '0);
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    step();
    step();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_taken", 64'(out_taken), 64'd0);
    check_eq("rst_out_target", 64'(out_target), 64'd0);
    check_eq("rst_total", 64'(total_cnt), 64'd0);
    check_eq("rst_taken", 64'(taken_cnt), 64'd0);
    check_eq("rst_flag_err", 64'(flag_err), 64'd0);
    rst = 1'b0;
    step();

    // Single push, cond lth with consistent flags lth/lte/neq.
    out_ready = 1'b1;
    drive(1'b1, 3'd2, 6'b001110, 32'hDEAD_0001);
    step();
    drive(1'b0, 3'd0, 6'b0, '0);
    check_eq("t1_out_valid", 64'(out_valid), 64'd1);
    check_eq("t1_out_taken", 64'(out_taken), 64'd1);
    check_eq("t1_out_target", 64'(out_target), 64'hDEAD_0001);
    check_eq("t1_total", 64'(total_cnt), 64'd1);
    check_eq("t1_taken", 64'(taken_cnt), 64'd1);
    check_eq("t1_flag_err", 64'(flag_err), 64'd0);
    step();
    check_eq("t1_drained", 64'(out_valid), 64'd0);

    // Back-pressure: three pushes, only two fit.
    out_ready = 1'b0;
    drive(1'b1, 3'd6, 6'b001110, 32'h2000_0001);
    step();
    check_eq("t2_ready_after1", 64'(in_ready), 64'd1);
    drive(1'b1, 3'd6, 6'b001110, 32'h2000_0002);
    step();
    check_eq("t2_ready_after2", 64'(in_ready), 64'd0);
    check_eq("t2_head1", 64'(out_target), 64'h2000_0001);
    drive(1'b1, 3'd6, 6'b001110, 32'h2000_0003);
    step();
    check_eq("t2_ready_full", 64'(in_ready), 64'd0);
    check_eq("t2_head_hold", 64'(out_target), 64'h2000_0001);
    check_eq("t2_valid_hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check_eq("t2_head2", 64'(out_target), 64'h2000_0002);
    check_eq("t2_ready_one", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 3'd0, 6'b0, '0);
    check_eq("t2_head3", 64'(out_target), 64'h2000_0003);
    check_eq("t2_valid3", 64'(out_valid), 64'd1);
    step();
    check_eq("t2_drained", 64'(out_valid), 64'd0);
    check_eq("t2_total", 64'(total_cnt), 64'd4);
    check_eq("t2_taken", 64'(taken_cnt), 64'd4);

    // Steady push+pop at occupancy one, cond never.
    drive(1'b1, 3'd7, 6'b001110, 32'h3000_0000);
    step();
    for (int i = 1; i <= 10; i++) begin
      in_target = 32'h3000_0000 + 32'(i);
      step();
      check_eq("t3_target", 64'(out_target), 64'(32'h3000_0000 + 32'(i)));
      check_eq("t3_in_ready", 64'(in_ready), 64'd1);
    end
    check_eq("t3_taken_never", 64'(out_taken), 64'd0);
    drive(1'b0, 3'd0, 6'b0, '0);
    step();
    check_eq("t3_drained", 64'(out_valid), 64'd0);
    check_eq("t3_total", 64'(total_cnt), 64'd15);
    check_eq("t3_taken", 64'(taken_cnt), 64'd4);
    check_eq("t3_total4", 64'(total_cnt4), 64'd15);

    // Decode sweep with a "greater than" flag set: gte,gth,neq.
    gt_expect = 8'b0111_0010;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 3'(c), 6'b110010, 32'h4000_0000 + 32'(c));
      step();
      check_eq("dec_taken", 64'(out_taken), 64'(gt_expect[c]));
    end
    drive(1'b0, 3'd0, 6'b0, '0);
    step();
    check_eq("dec_flag_err", 64'(flag_err), 64'd0);

    // Sticky flag error and clear priority.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_eq("t5_clr_total", 64'(total_cnt), 64'd0);
    drive(1'b1, 3'd0, 6'b000011, 32'h5000_0000);
    step();
    drive(1'b0, 3'd0, 6'b0, '0);
    check_eq("t5_err_set", 64'(flag_err), 64'd1);
    check_eq("t5_bad_taken", 64'(out_taken), 64'd1);
    check_eq("t5_bad_total", 64'(total_cnt), 64'd1);
    step();
    step();
    check_eq("t5_err_sticky", 64'(flag_err), 64'd1);
    drive(1'b1, 3'd2, 6'b001110, 32'h5000_0001);
    step();
    drive(1'b0, 3'd0, 6'b0, '0);
    check_eq("t5_err_sticky_good", 64'(flag_err), 64'd1);
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_eq("t5_err_cleared", 64'(flag_err), 64'd0);
    check_eq("t5_total_cleared", 64'(total_cnt), 64'd0);
    cnt_clr = 1'b1;
    drive(1'b1, 3'd6, 6'b000011, 32'h5100_0000);
    step();
    cnt_clr = 1'b0;
    drive(1'b0, 3'd0, 6'b0, '0);
    check_eq("t5_clrpush_total", 64'(total_cnt), 64'd0);
    check_eq("t5_clrpush_taken", 64'(taken_cnt), 64'd0);
    check_eq("t5_clrpush_err", 64'(flag_err), 64'd0);
    check_eq("t5_clrpush_fifo", 64'(out_target), 64'h5100_0000);
    step();

    // Saturation: 20 always-taken pushes.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'd6, 6'b001110, 32'h6000_0000 + 32'(i));
      step();
    end
    drive(1'b0, 3'd0, 6'b0, '0);
    step();
    check_eq("t4_total4_sat", 64'(total_cnt4), 64'd15);
    check_eq("t4_taken4_sat", 64'(taken_cnt4), 64'd15);
    check_eq("t4_total16", 64'(total_cnt), 64'd20);
    check_eq("t4_taken16", 64'(taken_cnt), 64'd20);

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    drive(1'b1, 3'd6, 6'b001110, 32'h7000_0001);
    step();
    in_target = 32'h7000_0002;
    step();
    drive(1'b0, 3'd0, 6'b0, '0);
    check_eq("t6_full", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("t6_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("t6_rst_total", 64'(total_cnt), 64'd0);
    step();
    rst = 1'b0;
    step();
    check_eq("t6_post_valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
